// File: rtl/pll_reset_pkg.sv
// Shared types and helpers for the PLL reset/lock supervisor.
package pll_reset_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    PERIPH_REL,
    RUN,
    FAIL
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val) + 1;
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_seq_sync_debounce.sv
// Two-flop synchroniser followed by an optional level debouncer.
// DEBOUNCE_CYCLES=0 passes the synchronised level straight through.
module sync_debounce
  import pll_reset_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned   DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'((DEBOUNCE_CYCLES == 0) ? 0 : DEBOUNCE_CYCLES - 1);

  logic            sync_q1;
  logic            sync_q2;
  logic            level_q;
  logic [DB_W-1:0] db_cnt;

  // The debounced level only follows the synchronised input after it has
  // differed from the current level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= RESET_LEVEL;
      db_cnt  <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == level_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level_q <= sync_q2;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign level = (DEBOUNCE_CYCLES == 0) ? sync_q2 : level_q;

endmodule

// File: rtl/pll_reset_seq.sv
// Reset/lock supervisor: drives PLL RESET, qualifies LOCK, retries on
// timeout and releases peripheral then CPU reset in a fixed order.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned STAGE_GAP_CYCLES    = 16,
  parameter int unsigned MAX_RETRIES         = 7,
  parameter int unsigned DEBOUNCE_CYCLES     = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock_i,
  input  logic       btn_rst_n_i,
  output logic       pll_reset_o,
  output logic       periph_reset_o,
  output logic       cpu_reset_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [2:0] retry_cnt_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int unsigned CNT_MAX = umax(umax(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                         umax(LOCK_TIMEOUT_CYCLES, STAGE_GAP_CYCLES));
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRIES);

  logic lock_s;
  logic btn_level;
  logic btn_press;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] stable_cnt, stable_nxt;
  logic [2:0]       retry_cnt, retry_nxt;
  logic [7:0]       lock_loss_cnt, loss_nxt;

  sync_debounce #(
    .DEBOUNCE_CYCLES(0),
    .RESET_LEVEL    (1'b0)
  ) u_lock_sync (
    .clk  (clk),
    .reset(reset),
    .raw  (pll_lock_i),
    .level(lock_s)
  );

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (1'b1)
  ) u_btn_debounce (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_rst_n_i),
    .level(btn_level)
  );

  assign btn_press = ~btn_level;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    stable_nxt = '0;
    retry_nxt  = retry_cnt;
    loss_nxt   = lock_loss_cnt;

    case (state)
      PLL_RST: begin
        cnt_nxt = cnt + 1'b1;
        if (btn_press) begin
          cnt_nxt = '0;
        end else if (cnt == RST_LAST) begin
          state_nxt = WAIT_LOCK;
        end
      end

      // Lock qualification wins over a timeout landing in the same cycle.
      WAIT_LOCK: begin
        cnt_nxt    = cnt + 1'b1;
        stable_nxt = lock_s ? stable_cnt + 1'b1 : '0;
        if (btn_press) begin
          state_nxt = PLL_RST;
        end else if (lock_s && (stable_cnt == STABLE_LAST)) begin
          state_nxt = PERIPH_REL;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry_cnt == RETRY_MAX) begin
            state_nxt = FAIL;
          end else begin
            retry_nxt = retry_cnt + 3'd1;
            state_nxt = PLL_RST;
          end
        end
      end

      PERIPH_REL, RUN: begin
        if (state == PERIPH_REL) begin
          cnt_nxt = cnt + 1'b1;
        end
        if (!lock_s || btn_press) begin
          state_nxt = PLL_RST;
        end else if ((state == PERIPH_REL) && (cnt == GAP_LAST)) begin
          state_nxt = RUN;
          retry_nxt = '0;
        end
        if (!lock_s && (lock_loss_cnt != 8'hFF)) begin
          loss_nxt = lock_loss_cnt + 8'd1;
        end
      end

      FAIL: begin
        if (btn_press) begin
          state_nxt = PLL_RST;
          retry_nxt = '0;
        end
      end

      default: begin
        state_nxt = PLL_RST;
      end
    endcase
  end

  // Counters restart on every state change; outputs decode the next state
  // so they move on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= PLL_RST;
      cnt             <= '0;
      stable_cnt      <= '0;
      retry_cnt       <= '0;
      lock_loss_cnt   <= '0;
      pll_reset_o     <= 1'b1;
      periph_reset_o  <= 1'b1;
      cpu_reset_o     <= 1'b1;
      ready_o         <= 1'b0;
      fail_o          <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= (state_nxt != state) ? '0 : cnt_nxt;
      stable_cnt      <= (state_nxt != state) ? '0 : stable_nxt;
      retry_cnt       <= retry_nxt;
      lock_loss_cnt   <= loss_nxt;
      pll_reset_o     <= (state_nxt == PLL_RST) || (state_nxt == FAIL);
      periph_reset_o  <= !((state_nxt == PERIPH_REL) || (state_nxt == RUN));
      cpu_reset_o     <= (state_nxt != RUN);
      ready_o         <= (state_nxt == RUN);
      fail_o          <= (state_nxt == FAIL);
    end
  end

  assign retry_cnt_o     = retry_cnt;
  assign lock_loss_cnt_o = lock_loss_cnt;

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Reset/lock supervisor sitting directly downstream of the FPGA PLL wrapper.
- Runs on the board reference clock (50 MHz), the same clock that feeds the PLL.
- Drives the PLL RESET pin and watches the PLL LOCK output. Qualifies lock for stability and retries on lock timeout.
- Releases the peripheral reset first, then the CPU reset, in a fixed order. Re-sequences on lock loss or a push-button reset.
- Destination clock domains re-synchronise periph_reset_o / cpu_reset_o locally; that logic is outside this block.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_reset_o is held high in each PLL reset phase.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock-high cycles required before lock is accepted.
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK before a retry.
- STAGE_GAP_CYCLES, 16: cycles between peripheral reset release and CPU reset release.
- MAX_RETRIES, 7: timeouts tolerated; the next timeout after that enters FAIL.
- DEBOUNCE_CYCLES, 65536: cycles the button must hold a level before the debounced level changes.

Ports:
- clk  in  1  board reference clock.
- reset  in  1  synchronous, active-high; one clock.
- pll_lock_i  in  1  PLL LOCK, asynchronous.
- btn_rst_n_i  in  1  board reset button, active-low, asynchronous, bouncy.
- pll_reset_o  out  1  to PLL RESET.
- periph_reset_o  out  1  active-high peripheral/bus reset.
- cpu_reset_o  out  1  active-high core reset.
- ready_o  out  1  high only in RUN.
- fail_o  out  1  sticky failure flag.
- retry_cnt_o  out  3  timeouts in the current attempt.
- lock_loss_cnt_o  out  8  saturating count of lock losses.

Behaviour:
- Reset value of every output/register while reset=1:
  - pll_reset_o=1, periph_reset_o=1, cpu_reset_o=1.
  - ready_o=0, fail_o=0.
  - retry_cnt_o=0, lock_loss_cnt_o=0.
  - state=PLL_RST, all counters 0, synchroniser flops 0, debounced button = released.
- Input conditioning:
  - pll_lock_i and btn_rst_n_i each pass a 2-flop synchroniser.
  - The synchronised button feeds the debouncer; btn_press = debounced level low.
  - Latency from the pin to a state-machine decision is 2 cycles for lock. For the button it is 2 + DEBOUNCE_CYCLES.
- All outputs are registered and are decoded from the next state, so they change in the cycle the state changes.
- PLL_RST:
  - Outputs: pll_reset_o=1, both resets=1.
  - Counter increments each cycle. At PLL_RST_CYCLES-1 → WAIT_LOCK, unless btn_press, which holds the counter at 0.
  - pll_reset_o is therefore high for exactly PLL_RST_CYCLES cycles after reset falls.
- WAIT_LOCK:
  - Outputs: pll_reset_o=0.
  - Stable counter increments while lock_s=1 and clears when lock_s=0. Timeout counter increments every cycle.
  - Stable count reaches LOCK_STABLE_CYCLES → PERIPH_REL; this has priority over timeout in the same cycle.
  - Timeout count reaches LOCK_TIMEOUT_CYCLES:
    - if retry_cnt==MAX_RETRIES → FAIL;
    - else retry_cnt+1 and → PLL_RST.
  - btn_press → PLL_RST.
- PERIPH_REL:
  - Outputs: periph_reset_o=0, cpu_reset_o=1.
  - After STAGE_GAP_CYCLES → RUN and retry_cnt cleared.
- RUN:
  - Outputs: periph_reset_o=0, cpu_reset_o=0, ready_o=1.
- Lock loss or button exit (PERIPH_REL or RUN):
  - lock_s=0 → next cycle PLL_RST with all resets asserted; lock_loss_cnt+1, saturating at 255.
  - btn_press → PLL_RST with lock_loss_cnt unchanged.
  - If both occur in the same cycle, the transition is identical and lock_loss_cnt still increments.
- FAIL:
  - Outputs: pll_reset_o=1, all resets=1, fail_o=1. The state is sticky.
  - Exit only via reset or btn_press → PLL_RST, with retry_cnt and fail_o cleared.
- Counter widths: $clog2 of the largest parameter + 1. No wrap: each counter is cleared on every state entry.
- Reset asserted mid-sequence: next cycle, all registers return to their reset values regardless of state.

Decomposition:
- Package pll_reset_pkg holds:
  - the state enum: PLL_RST, WAIT_LOCK, PERIPH_REL, RUN, FAIL;
  - the localparam width function.
- One natural sub-module: sync_debounce (2-flop synchroniser + debounce counter, parameter DEBOUNCE_CYCLES). It is instantiated once for the button; lock uses only the synchroniser part (DEBOUNCE_CYCLES=0 bypass).

Test Plan:
- Bench parameters: PLL_RST_CYCLES=4, LOCK_STABLE=8, TIMEOUT=32, GAP=4, MAX_RETRIES=2, DEBOUNCE=4.
- Nominal: lock rises 10 cycles after reset release and stays high.
  - pll_reset_o low at cycle 4.
  - periph_reset_o falls 2+8 cycles after lock.
  - cpu_reset_o falls 4 cycles later; ready_o=1.
- Glitchy lock: lock high 5 cycles, low 1, then steady → stable counter restarts; periph release 10 cycles after the final rise.
- Never lock → 3 timeouts with retry_cnt_o 1,2 and pll_reset_o pulsed 4 cycles each time; the third timeout gives fail_o=1 and all resets held. A button press then clears fail_o and retries.
- Lock drop in RUN for 1 cycle → all resets asserted 3 cycles later, lock_loss_cnt_o=1, full re-sequence. 256 drops → counter holds at 255.
- Button bounce: pulses of 2 cycles are ignored. A 6-cycle hold from RUN → PLL_RST, and pll_reset_o stays high while the button is held.
- Reset asserted in PERIPH_REL → next cycle, all outputs are back at their reset values.
